spdif_transmitter: RTL and testbench

Serial S/PDIF-style transmitter that sends parallel words of WIDTH bits using biphase-mark coding (BMC), LSB first. Each clock cycle carries exactly one data bit cell, presented as two half-cell line levels on a 2-bit output. The block sits between a parallel sample source and a line driver or serializer, and it loops continuously over successive words.

---
 rtl/spdif_transmitter.sv | 70 +++++++
 tb/tb_spdif_transmitter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/spdif_transmitter.sv
// S/PDIF-style biphase-mark (BMC) serializer: one bit cell per clock, LSB first,
// continuous back-to-back words with the line level carried across word boundaries.
module spdif_transmitter #(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clock,
  input  logic             nreset,     // synchronous, active-high despite the name
  input  logic [WIDTH-1:0] Tx,
  output logic [1:0]       SerialData  // [1] first half-cell, [0] second half-cell
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  // Bit index keeps this exact name; external benches probe it hierarchically.
  logic [CW-1:0]    CounterBit;
  logic [CW-1:0]    counter_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             level_q, level_d;
  logic [1:0]       serial_q, serial_d;

  logic             bit_c;
  logic             first_c;
  logic             second_c;

  // Bit select, BMC encode and index advance for the current cell.
  always_comb begin
    counter_d = CounterBit;
    word_d    = word_q;
    level_d   = level_q;
    serial_d  = serial_q;
    bit_c     = 1'b0;
    first_c   = 1'b0;
    second_c  = 1'b0;

    // Index 0 sends straight from Tx while capturing it for the rest of the word.
    if (CounterBit == '0) begin
      bit_c  = Tx[0];
      word_d = Tx;
    end else begin
      bit_c  = word_q[CounterBit];
    end

    // Every cell opens with a transition; a '1' adds a mid-cell transition.
    first_c  = ~level_q;
    second_c = bit_c ? level_q : ~level_q;
    serial_d = {first_c, second_c};
    level_d  = second_c;

    counter_d = (CounterBit == LAST_IDX) ? '0 : CounterBit + CW'(1);
  end

  // State registers with synchronous reset that abandons any word in flight.
  always_ff @(posedge clock) begin
    if (nreset) begin
      CounterBit <= '0;
      word_q     <= '0;
      level_q    <= 1'b0;
      serial_q   <= 2'b00;
    end else begin
      CounterBit <= counter_d;
      word_q     <= word_d;
      level_q    <= level_d;
      serial_q   <= serial_d;
    end
  end

  assign SerialData = serial_q;

endmodule

// File: tb/tb_spdif_transmitter.sv
// Self-checking bench for spdif_transmitter: directed scenarios plus a random run,
// compared against a line-level BMC reference model.
module tb_spdif_transmitter;

  localparam int unsigned W = 11;

  logic         clock;
  logic         nreset;
  logic [W-1:0] Tx;
  logic [1:0]   SerialData;

  int errors;
  int checks;

  // Reference model state: position in word, captured word, current line level.
  int           m_idx;
  logic [W-1:0] m_word;
  logic         m_line;

  spdif_transmitter #(.WIDTH(W)) dut (
    .clock      (clock),
    .nreset     (nreset),
    .Tx         (Tx),
    .SerialData (SerialData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Apply inputs for one edge, advance the model, then compare after the edge.
  task automatic tick(input logic rst, input logic [W-1:0] tx);
    logic [1:0] exp_ser;
    logic       b;
    logic       h1;
    logic       h2;
    nreset = rst;
    Tx     = tx;
    @(posedge clock);
    #1;
    if (rst) begin
      m_idx   = 0;
      m_word  = '0;
      m_line  = 1'b0;
      exp_ser = 2'b00;
    end else begin
      if (m_idx == 0) m_word = tx;
      b  = m_word[m_idx];
      h1 = !m_line;             // cell boundary always flips the line
      h2 = b ? !h1 : h1;        // a one flips again mid-cell
      m_line  = h2;
      exp_ser = {h1, h2};
      m_idx   = (m_idx + 1) % W;
    end
    check("serial", 32'(SerialData), 32'(exp_ser));
    check("counter", 32'(dut.CounterBit), 32'(m_idx));
  endtask

  logic [1:0]   tab [W];
  logic [W-1:0] tx0;
  logic [W-1:0] txr;

  initial begin
    errors = 0;
    checks = 0;
    m_idx  = 0;
    m_word = '0;
    m_line = 1'b0;
    nreset = 1'b1;
    Tx     = '0;
    tab = '{2'b10, 2'b11, 2'b00, 2'b11, 2'b00, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01};
    tx0 = 11'b11110100001;

    // Reset held for two edges.
    tick(1'b1, tx0);
    tick(1'b1, tx0);
    check("reset_serial", 32'(SerialData), 32'h0);

    // First word against the known waveform, then wrap with the same word.
    for (int i = 0; i < int'(W); i++) begin
      tick(1'b0, tx0);
      check("table", 32'(SerialData), 32'(tab[i]));
    end
    tick(1'b0, tx0);
    check("wrap_bit0", 32'(SerialData), 32'b01);
    for (int i = 1; i < int'(W); i++) tick(1'b0, tx0);

    // Mid-word Tx change at index 4 must not disturb the word in flight.
    while (m_idx != 4) tick(1'b0, tx0);
    for (int i = 0; i < 8; i++) tick(1'b0, 11'h5A3);
    while (m_idx != 0) tick(1'b0, 11'h5A3);

    // Switch to all zeros during the last-bit cycle: next word has no mid-cell flips.
    while (m_idx != int'(W) - 1) tick(1'b0, 11'h5A3);
    tick(1'b0, 11'h000);
    for (int i = 0; i < int'(W); i++) begin
      tick(1'b0, 11'h000);
      check("zero_nomid", 32'(SerialData[1] ^ SerialData[0]), 32'h0);
    end

    // All ones from reset: every cell is 10.
    tick(1'b1, 11'h7FF);
    for (int i = 0; i < 2 * int'(W); i++) begin
      tick(1'b0, 11'h7FF);
      check("ones", 32'(SerialData), 32'b10);
    end

    // Reset in the middle of a word, then restart from bit 0 with level 0.
    while (m_idx != 6) tick(1'b0, 11'h3C5);
    tick(1'b1, 11'h3C5);
    check("midrst_serial", 32'(SerialData), 32'h0);
    tick(1'b0, 11'h2B6);
    check("midrst_bit0", 32'(SerialData), 32'b11);
    for (int i = 0; i < 2 * int'(W); i++) tick(1'b0, 11'h2B6);

    // Random run: Tx churns every cycle, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      txr = W'($urandom);
      tick(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, txr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
